ad_nios_cmp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one wide equality comparator among several requesters on the main PLD. The comparator is built from a cascade-chained logic-cell pipeline. Each requester (address-match, channel-ID and trigger-word clients) posts an operand pair. The block grants one requester at a time, latches its operands into the comparator, waits out the fixed pipeline latency, and returns a single-cycle `done` strobe with the match result to the granted requester.

---
 rtl/ad_nios_cmp_arbiter.sv | 132 +++++++++++++
 tb/tb_ad_nios_cmp_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ad_nios_cmp_arbiter.sv
// Round-robin arbiter sharing one wide equality comparator among N_REQ requesters.
// Optional per-bit compare mask enabled by defining AD_NIOS_CMP_MASK_EN.
module ad_nios_cmp_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int CMP_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
`ifdef AD_NIOS_CMP_MASK_EN
    input  logic [N_REQ*WIDTH-1:0]   req_mask,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     match,
    output logic                     busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (CMP_LAT > 2) ? $clog2(CMP_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    ptr, ptr_nx, sel, sel_nx, win, cand;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] op_a, op_b, a_nx, b_nx;
    logic [N_REQ-1:0] gnt_nx, done_nx;
    logic             match_nx, busy_nx, found, hit;

`ifdef AD_NIOS_CMP_MASK_EN
    logic [WIDTH-1:0] op_m, m_nx;
    assign hit = ((op_a ^ op_b) & op_m) == '0;
`else
    assign hit = (op_a == op_b);
`endif

    // First set request bit at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = '0;
        done_nx  = '0;
        match_nx = 1'b0;
        busy_nx  = busy;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        sel_nx   = sel;
        a_nx     = op_a;
        b_nx     = op_b;
`ifdef AD_NIOS_CMP_MASK_EN
        m_nx     = op_m;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx    = EVAL;
                    gnt_nx[win] = 1'b1;
                    sel_nx      = win;
                    a_nx        = req_a[int'(win)*WIDTH +: WIDTH];
                    b_nx        = req_b[int'(win)*WIDTH +: WIDTH];
`ifdef AD_NIOS_CMP_MASK_EN
                    m_nx        = req_mask[int'(win)*WIDTH +: WIDTH];
`endif
                    cnt_nx      = CW'(CMP_LAT - 1);
                    busy_nx     = 1'b1;
                end
            end
            EVAL: begin
                if (cnt == '0) begin
                    state_nx     = RESP;
                    done_nx[sel] = 1'b1;
                    match_nx     = hit;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                ptr_nx   = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            match <= 1'b0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
            sel   <= '0;
            op_a  <= '0;
            op_b  <= '0;
`ifdef AD_NIOS_CMP_MASK_EN
            op_m  <= '0;
`endif
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            match <= match_nx;
            busy  <= busy_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            sel   <= sel_nx;
            op_a  <= a_nx;
            op_b  <= b_nx;
`ifdef AD_NIOS_CMP_MASK_EN
            op_m  <= m_nx;
`endif
        end
    end
endmodule

// File: tb/tb_ad_nios_cmp_arbiter.sv
// Bench for ad_nios_cmp_arbiter: directed scenarios plus randomized traffic against a
// timestamp-based service model; covers the AD_NIOS_CMP_MASK_EN build when defined.
module tb_ad_nios_cmp_arbiter;
    localparam int N_REQ   = 4;
    localparam int WIDTH   = 32;
    localparam int CMP_LAT = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req, gnt, done;
    logic [N_REQ*WIDTH-1:0] req_a, req_b;
    logic                   match, busy;
`ifdef AD_NIOS_CMP_MASK_EN
    logic [N_REQ*WIDTH-1:0] req_mask;
`endif

    int vectors = 0, errors = 0;
    // Model: grant edge, granted index, done edge, edge at which the block is free again.
    int cyc = 0, g_cyc = -100, d_cyc = -100, free_cyc = 0, g_idx = 0, m_ptr = 0;
    bit m_val = 1'b0;

    always #5 clk = ~clk;

    ad_nios_cmp_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CMP_LAT(CMP_LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
`ifdef AD_NIOS_CMP_MASK_EN
        .req_mask(req_mask),
`endif
        .gnt(gnt), .done(done), .match(match), .busy(busy)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] sl(logic [N_REQ*WIDTH-1:0] v, int i);
        return v[i*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        g_cyc = -100; d_cyc = -100; free_cyc = 0; m_ptr = 0;
    endtask

    task automatic model_edge();
        int w;
        logic [WIDTH-1:0] m;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        if (cyc >= free_cyc && req != '0) begin
            w = -1;
            for (int k = 0; k < N_REQ; k++)
                if (w < 0 && req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
            m = '1;
`ifdef AD_NIOS_CMP_MASK_EN
            m = sl(req_mask, w);
`endif
            m_val    = ((sl(req_a, w) ^ sl(req_b, w)) & m) == '0;
            g_idx    = w;
            g_cyc    = cyc;
            d_cyc    = cyc + CMP_LAT;
            free_cyc = cyc + CMP_LAT + 2;
            m_ptr    = (w + 1) % N_REQ;
        end
    endtask

    task automatic compare();
        logic [N_REQ-1:0] eg, ed;
        eg = (cyc == g_cyc) ? (N_REQ'(1) << g_idx) : '0;
        ed = (cyc == d_cyc) ? (N_REQ'(1) << g_idx) : '0;
        check("gnt",   32'(gnt),   32'(eg));
        check("done",  32'(done),  32'(ed));
        check("match", 32'(match), 32'((cyc == d_cyc) ? m_val : 1'b0));
        check("busy",  32'(busy),  32'(cyc >= g_cyc && cyc <= d_cyc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; req_a = '0; req_b = '0;
`ifdef AD_NIOS_CMP_MASK_EN
        req_mask = '1;
`endif
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_match", 32'(match), 0);
        check("rst_busy", 32'(busy), 0);

        // Round robin with all requesters held high from reset.
        req = '1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 17; s++) begin
            step();
            check("rr_gnt", 32'(gnt), (s % 4 == 0) ? (32'd1 << ((s / 4) % 4)) : 32'd0);
        end
        req = '0;
        repeat (5) step();

        // Single request, equal operands.
        req = 4'b0010;
        req_a[63:32] = 32'h1234_5678; req_b[63:32] = 32'h1234_5678;
        step(); check("single_gnt", 32'(gnt), 32'b0010); check("single_busy", 32'(busy), 1);
        req = '0;
        step(); check("single_gnt_low", 32'(gnt), 0);
        step(); check("single_done", 32'(done), 32'b0010); check("single_match", 32'(match), 1);
        step(); check("single_busy_low", 32'(busy), 0); check("single_done_low", 32'(done), 0);

        // Mismatch; operand A changes after grant and must not matter.
        req = 4'b0001;
        req_a[31:0] = 32'hFFFF_0000; req_b[31:0] = 32'hFFFF_0001;
        step(); check("mis_gnt", 32'(gnt), 32'b0001);
        req = '0; req_a[31:0] = 32'hFFFF_0001;
        step();
        step(); check("mis_done", 32'(done), 32'b0001); check("mis_match", 32'(match), 0);
        step();

        // Withdrawn request: requester 0 drops before it can be granted.
        req = 4'b1000;
        step(); check("wd_gnt3", 32'(gnt), 32'b1000);
        req = 4'b0011;
        step();
        req = 4'b0010;
        step(); step();
        step(); check("wd_gnt1", 32'(gnt), 32'b0010);
        req = '0;
        repeat (3) step();

        // Reset during EVAL for requester 2.
        req = 4'b0100;
        step(); check("rm_gnt", 32'(gnt), 32'b0100);
        req = '0;
        step();
        reset = 1'b1;
        #1;
        check("rm_gnt0", 32'(gnt), 0);
        check("rm_done0", 32'(done), 0);
        check("rm_match0", 32'(match), 0);
        check("rm_busy0", 32'(busy), 0);
        model_reset();
        step(); step();
        reset = 1'b0;
        req = 4'b0100;
        step(); check("rm_regnt", 32'(gnt), 32'b0100);
        req = '0;
        repeat (3) step();

`ifdef AD_NIOS_CMP_MASK_EN
        req = 4'b0001;
        req_a[31:0] = 32'h0000_00FF; req_b[31:0] = 32'h0000_00F0; req_mask[31:0] = 32'hFFFF_FF00;
        step(); req = '0; step();
        step(); check("mask_match1", 32'(match), 1);
        step();
        req = 4'b0001; req_mask[31:0] = 32'hFFFF_FFFF;
        step(); req = '0; step();
        step(); check("mask_match0", 32'(match), 0);
        step();
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int it = 0; it < 3000; it++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i])       req[i] = ($urandom_range(0, 3) == 0);
                else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                req_a[i*WIDTH +: WIDTH] = $urandom;
                req_b[i*WIDTH +: WIDTH] = $urandom_range(0, 1) ? req_a[i*WIDTH +: WIDTH]
                    : req_a[i*WIDTH +: WIDTH] ^ (32'd1 << $urandom_range(0, WIDTH - 1));
`ifdef AD_NIOS_CMP_MASK_EN
                req_mask[i*WIDTH +: WIDTH] = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
`endif
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
